// File: rtl/dlx_mem_pkg.sv
// Shared types for the DLX memory router: FSM states, access size codes, lane masks.
// No logic of its own; imported by the router and its lane aligner.
package dlx_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   localparam int unsigned REGION_RAM = 0;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] m;
      case (size)
         SIZE_BYTE: m = 4'b0001 << a;
         SIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: m = 4'b1111;
         default:   m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dlx_lane_align.sv
// Byte-lane mask, misalign/size fault, write replication and read right-alignment.
// Purely combinational, zero latency, no flow control.
module dlx_lane_align
   import dlx_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  a,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  mask,
   output logic        fault,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_al
);

   always_comb begin
      mask      = lane_mask(size, a);
      fault     = (size == SIZE_RSVD) ||
                  ((size == SIZE_HALF) && a[0]) ||
                  ((size == SIZE_WORD) && (a != 2'b00));
      wdata_rep = wdata;
      rdata_al  = rdata_raw;
      case (size)
         SIZE_BYTE: begin
            wdata_rep = {4{wdata[7:0]}};
            rdata_al  = {24'b0, rdata_raw[{a, 3'b000} +: 8]};
         end
         SIZE_HALF: begin
            wdata_rep = {2{wdata[15:0]}};
            rdata_al  = {16'b0, (a[1] ? rdata_raw[31:16] : rdata_raw[15:0])};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dlx_mem_router.sv
// Routes DLX data accesses to byte-lane RAM or 1-bit VRAM banks: ack 2+WS cycles after sample (faults 1).
// Requester holds cpu_req until cpu_ack; the VGA read port is a free-running 2-stage pipe.
module dlx_mem_router
   import dlx_mem_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int BANK_AW    = 12,
   parameter int VRAM_BANKS = 5,
   parameter int RAM_WS     = 0,
   parameter int VRAM_WS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [1:0]            cpu_size,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic                  cpu_ack,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_err,
   output logic                  err_sticky,
   input  logic                  err_clr,
   output logic [3:0]            ram_en,
   output logic                  ram_we,
   output logic [BANK_AW-3:0]    ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata,
   output logic [VRAM_BANKS-1:0] vram_en,
   output logic                  vram_we,
   output logic [BANK_AW-1:0]    vram_addr,
   output logic                  vram_wdata,
   input  logic [VRAM_BANKS-1:0] vram_rdata,
   input  logic [ADDR_W-1:0]     vga_addr,
   output logic [BANK_AW-1:0]    vga_baddr,
   input  logic [VRAM_BANKS-1:0] vga_bdata,
   output logic                  vga_pixel
);

   localparam int RW = ADDR_W - BANK_AW;
   localparam logic [RW-1:0] LAST_BANK = RW'(VRAM_BANKS);

   state_t               state_q, state_d;
   logic [RW-1:0]        region_q;
   logic [BANK_AW-1:0]   addr_q;
   logic                 we_q;
   logic [1:0]           size_q;
   logic [31:0]          wdata_q;
   logic                 err_q;
   logic [3:0]           cnt_q;

   logic                 idle, is_ram, dec_fault, al_fault, vbit, accept;
   logic [RW-1:0]        cpu_region;
   logic [3:0]           ws_sel, al_mask;
   logic [1:0]           al_size, al_a;
   logic [31:0]          al_wdata, al_rdata;

   assign idle       = (state_q == ST_IDLE);
   assign cpu_region = cpu_addr[ADDR_W-1:BANK_AW];
   assign is_ram     = (region_q == RW'(REGION_RAM));
   assign ws_sel     = is_ram ? 4'(RAM_WS) : 4'(VRAM_WS);

   // One aligner serves both the IDLE decode (live inputs) and the access itself (latched).
   assign al_size = idle ? cpu_size       : size_q;
   assign al_a    = idle ? cpu_addr[1:0]  : addr_q[1:0];

   dlx_lane_align u_align (
      .size      (al_size),
      .a         (al_a),
      .wdata     (wdata_q),
      .rdata_raw (ram_rdata),
      .mask      (al_mask),
      .fault     (al_fault),
      .wdata_rep (al_wdata),
      .rdata_al  (al_rdata)
   );

   assign dec_fault  = al_fault || (cpu_region > LAST_BANK);
   assign accept     = idle && cpu_req;
   assign ram_addr   = addr_q[BANK_AW-1:2];
   assign ram_wdata  = al_wdata;
   assign vram_addr  = addr_q;
   assign vram_wdata = wdata_q[0];

   always_comb begin
      state_d   = state_q;
      ram_en    = 4'b0000;
      ram_we    = 1'b0;
      vram_en   = '0;
      vram_we   = 1'b0;
      cpu_ack   = 1'b0;
      cpu_err   = 1'b0;
      cpu_rdata = 32'b0;
      vbit      = 1'b0;
      for (int b = 0; b < VRAM_BANKS; b++) begin
         if (region_q == RW'(b + 1)) vbit = vram_rdata[b];
      end
      case (state_q)
         ST_IDLE: begin
            if (cpu_req) state_d = dec_fault ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            if (is_ram) begin
               ram_en = al_mask;
               ram_we = we_q;
            end else begin
               for (int b = 0; b < VRAM_BANKS; b++) begin
                  vram_en[b] = (region_q == RW'(b + 1));
               end
               vram_we = we_q;
            end
            state_d = (ws_sel != 4'd0) ? ST_WAIT : ST_RESP;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
         end
         ST_RESP: begin
            cpu_ack = 1'b1;
            cpu_err = err_q;
            if (!err_q) cpu_rdata = is_ram ? al_rdata : {31'b0, vbit};
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         region_q   <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         size_q     <= SIZE_BYTE;
         wdata_q    <= 32'b0;
         err_q      <= 1'b0;
         cnt_q      <= 4'd0;
         err_sticky <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            region_q <= cpu_region;
            addr_q   <= cpu_addr[BANK_AW-1:0];
            we_q     <= cpu_we;
            size_q   <= cpu_size;
            wdata_q  <= cpu_wdata;
            err_q    <= dec_fault;
         end
         // WAIT lasts exactly ws_sel cycles: load ws-1, leave on zero.
         if (state_q == ST_ACCESS) cnt_q <= ws_sel - 4'd1;
         else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) cnt_q <= cnt_q - 4'd1;
         if (accept && dec_fault) err_sticky <= 1'b1;
         else if (err_clr)        err_sticky <= 1'b0;
      end
   end

   // VGA pipe: banks register the pixel address themselves, we carry the bank index alongside.
   logic [RW-1:0] vga_region, vga_bank_q;
   logic          vga_ok_q, vga_pix_d;

   assign vga_region = vga_addr[ADDR_W-1:BANK_AW];
   assign vga_baddr  = vga_addr[BANK_AW-1:0];

   always_comb begin
      vga_pix_d = 1'b0;
      for (int b = 0; b < VRAM_BANKS; b++) begin
         if (vga_ok_q && (vga_bank_q == RW'(b))) vga_pix_d = vga_bdata[b];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_bank_q <= '0;
         vga_ok_q   <= 1'b0;
         vga_pixel  <= 1'b0;
      end else begin
         vga_bank_q <= vga_region - RW'(1);
         vga_ok_q   <= (vga_region != '0) && (vga_region <= LAST_BANK);
         vga_pixel  <= vga_pix_d;
      end
   end

endmodule

// File: tb/tb_dlx_mem_router.sv
// Directed bench for dlx_mem_router with behavioural RAM/VRAM models.
module tb_dlx_mem_router;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tb_clr = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, err_clr = 1'b0;
   logic [1:0]  cpu_size = 2'b00;
   logic [15:0] cpu_addr = '0, vga_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_ack, cpu_err, err_sticky, ram_we, vram_we, vram_wdata, vga_pixel;
   logic [31:0] cpu_rdata, ram_wdata, ram_rdata;
   logic [3:0]  ram_en;
   logic [9:0]  ram_addr;
   logic [4:0]  vram_en, vram_rdata, vga_bdata;
   logic [11:0] vram_addr, vga_baddr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dlx_mem_router dut (
      .clk(clk), .reset(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .err_sticky(err_sticky), .err_clr(err_clr),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
      .vram_rdata(vram_rdata),
      .vga_addr(vga_addr), .vga_baddr(vga_baddr), .vga_bdata(vga_bdata), .vga_pixel(vga_pixel)
   );

   // Synchronous read-first memories; outputs hold while not enabled.
   logic [7:0] rmem [1024][4];
   logic       vmem [5][4096];

   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 1024; i++) for (int l = 0; l < 4; l++) rmem[i][l] <= 8'h00;
         for (int b = 0; b < 5; b++) for (int i = 0; i < 4096; i++) vmem[b][i] <= 1'b0;
         ram_rdata  <= '0;
         vram_rdata <= '0;
         vga_bdata  <= '0;
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (ram_en[l]) begin
               if (ram_we) rmem[ram_addr][l] <= ram_wdata[8*l +: 8];
               ram_rdata[8*l +: 8] <= rmem[ram_addr][l];
            end
         end
         for (int b = 0; b < 5; b++) begin
            if (vram_en[b]) begin
               if (vram_we) vmem[b][vram_addr] <= vram_wdata;
               vram_rdata[b] <= vmem[b][vram_addr];
            end
            vga_bdata[b] <= vmem[b][vga_baddr];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [3:0]  ram_en;
      logic [4:0]  vram_en;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SR = 2'b11;

   task automatic run_access(input vec_t v, output int lat, output logic [3:0] ren,
                             output logic [4:0] ven, output logic wes,
                             output logic [31:0] rd, output logic er);
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = v.we; cpu_size = v.size; cpu_addr = v.addr; cpu_wdata = v.wdata;
      lat = -1; ren = '0; ven = '0; wes = 1'b0; rd = '0; er = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         ren |= ram_en;
         ven |= vram_en;
         wes |= ram_we | vram_we;
         if (cpu_ack) begin
            lat = c; rd = cpu_rdata; er = cpu_err;
            break;
         end
      end
      cpu_req = 1'b0;
   endtask

   vec_t vt [24];
   vec_t v;
   int          lat;
   logic [3:0]  ren;
   logic [4:0]  ven;
   logic        wes, er;
   logic [31:0] rd;
   logic [15:0] vga_a [10];
   logic        vga_e [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{1'b1, SW, 16'h0010, 32'hDEADBEEF, 2, 4'hF, 5'h00, 32'h0,          1'b0};
      vt[1]  = '{1'b0, SW, 16'h0010, 32'h0,        2, 4'hF, 5'h00, 32'hDEADBEEF,   1'b0};
      vt[2]  = '{1'b0, SB, 16'h0013, 32'h0,        2, 4'h8, 5'h00, 32'h000000DE,   1'b0};
      vt[3]  = '{1'b0, SH, 16'h0012, 32'h0,        2, 4'hC, 5'h00, 32'h0000DEAD,   1'b0};
      vt[4]  = '{1'b0, SB, 16'h0010, 32'h0,        2, 4'h1, 5'h00, 32'h000000EF,   1'b0};
      vt[5]  = '{1'b1, SH, 16'h0016, 32'h1234ABCD, 2, 4'hC, 5'h00, 32'h0,          1'b0};
      vt[6]  = '{1'b1, SB, 16'h0015, 32'h00000077, 2, 4'h2, 5'h00, 32'h0,          1'b0};
      vt[7]  = '{1'b0, SW, 16'h0014, 32'h0,        2, 4'hF, 5'h00, 32'hABCD7700,   1'b0};
      vt[8]  = '{1'b0, SH, 16'h0014, 32'h0,        2, 4'h3, 5'h00, 32'h00007700,   1'b0};
      vt[9]  = '{1'b1, SB, 16'h2005, 32'h00000001, 3, 4'h0, 5'h02, 32'h0,          1'b0};
      vt[10] = '{1'b0, SB, 16'h2005, 32'h0,        3, 4'h0, 5'h02, 32'h00000001,   1'b0};
      vt[11] = '{1'b0, SB, 16'h2006, 32'h0,        3, 4'h0, 5'h02, 32'h0,          1'b0};
      vt[12] = '{1'b1, SB, 16'h2005, 32'hFFFFFFFE, 3, 4'h0, 5'h02, 32'h0,          1'b0};
      vt[13] = '{1'b0, SB, 16'h2005, 32'h0,        3, 4'h0, 5'h02, 32'h0,          1'b0};
      vt[14] = '{1'b1, SB, 16'h5FFF, 32'h00000001, 3, 4'h0, 5'h10, 32'h0,          1'b0};
      vt[15] = '{1'b0, SB, 16'h5FFF, 32'h0,        3, 4'h0, 5'h10, 32'h00000001,   1'b0};
      vt[16] = '{1'b1, SB, 16'h1000, 32'h00000001, 3, 4'h0, 5'h01, 32'h0,          1'b0};
      vt[17] = '{1'b1, SB, 16'h3000, 32'h00000001, 3, 4'h0, 5'h04, 32'h0,          1'b0};
      vt[18] = '{1'b0, SB, 16'h5000, 32'h0,        3, 4'h0, 5'h10, 32'h0,          1'b0};
      vt[19] = '{1'b0, SW, 16'h0002, 32'h0,        1, 4'h0, 5'h00, 32'h0,          1'b1};
      vt[20] = '{1'b0, SH, 16'h0011, 32'h0,        1, 4'h0, 5'h00, 32'h0,          1'b1};
      vt[21] = '{1'b0, SR, 16'h0010, 32'h0,        1, 4'h0, 5'h00, 32'h0,          1'b1};
      vt[22] = '{1'b1, SB, 16'h6000, 32'h00000001, 1, 4'h0, 5'h00, 32'h0,          1'b1};
      vt[23] = '{1'b0, SW, 16'hF000, 32'h0,        1, 4'h0, 5'h00, 32'h0,          1'b1};

      vga_a = '{16'h1000, 16'h5FFF, 16'h6000, 16'h1001, 16'h0000,
                16'h3000, 16'h2000, 16'h2005, 16'h5000, 16'h3000};
      vga_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(cpu_ack), 32'd0);
      check("rst_sticky", 32'(err_sticky), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_vram_en", 32'(vram_en), 32'd0);
      check("rst_we", 32'({ram_we, vram_we}), 32'd0);
      check("rst_pixel", 32'(vga_pixel), 32'd0);
      tb_clr = 1'b0;
      rst_n  = 1'b1;

      for (int i = 0; i < 24; i++) begin
         v = vt[i];
         if (i == 19) check("sticky_before_fault", 32'(err_sticky), 32'd0);
         run_access(v, lat, ren, ven, wes, rd, er);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
         check($sformatf("v%0d_ram_en", i), 32'(ren), 32'(v.ram_en));
         check($sformatf("v%0d_vram_en", i), 32'(ven), 32'(v.vram_en));
         check($sformatf("v%0d_we", i), 32'(wes), 32'(v.we & ~v.err));
         check($sformatf("v%0d_err", i), 32'(er), 32'(v.err));
         if (!v.we || v.err) check($sformatf("v%0d_rdata", i), rd, v.rdata);
         @(negedge clk);
         check($sformatf("v%0d_ack_pulse", i), 32'(cpu_ack), 32'd0);
         check($sformatf("v%0d_rdata_idle", i), cpu_rdata, 32'd0);
      end

      // Sticky error: survives a good access, cleared by err_clr, set wins over clear
      check("sticky_set", 32'(err_sticky), 32'd1);
      run_access(vt[1], lat, ren, ven, wes, rd, er);
      check("sticky_hold", 32'(err_sticky), 32'd1);
      check("sticky_hold_rdata", rd, 32'hDEADBEEF);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      check("sticky_clr", 32'(err_sticky), 32'd0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = SW; cpu_addr = 16'h0001; err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("sticky_set_wins", 32'(err_sticky), 32'd1);
      check("sticky_set_wins_ack", 32'({cpu_ack, cpu_err}), 32'd3);
      cpu_req = 1'b0;
      @(negedge clk);

      // Reset during ACCESS: enables drop asynchronously, no ack
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = SB; cpu_addr = 16'h5FFF;
      @(negedge clk);
      check("rstA_en_before", 32'(vram_en), 32'h10);
      rst_n = 1'b0;
      #1;
      check("rstA_en_async", 32'({ram_en, vram_en}), 32'd0);
      cpu_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("rstA_no_ack%0d", c), 32'(cpu_ack), 32'd0);
      end
      check("rstA_sticky", 32'(err_sticky), 32'd0);
      rst_n = 1'b1;
      run_access(vt[15], lat, ren, ven, wes, rd, er);
      check("rstA_after_lat", 32'(lat), 32'd3);
      check("rstA_after_rdata", rd, 32'd1);

      // Reset during WAIT
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = SB; cpu_addr = 16'h2005;
      @(negedge clk);
      @(negedge clk);
      check("rstW_in_wait", 32'({cpu_ack, vram_en}), 32'd0);
      rst_n = 1'b0;
      cpu_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("rstW_no_ack%0d", c), 32'(cpu_ack), 32'd0);
      end
      rst_n = 1'b1;
      run_access(vt[1], lat, ren, ven, wes, rd, er);
      check("rstW_after_lat", 32'(lat), 32'd2);
      check("rstW_after_rdata", rd, 32'hDEADBEEF);

      // VGA stream: pixel for the address driven at negedge k appears at negedge k+2
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k >= 2) check($sformatf("vga_%h", vga_a[k-2]), 32'(vga_pixel), 32'(vga_e[k-2]));
         if (k < 10) vga_a_drive(k);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   task automatic vga_a_drive(input int k);
      vga_addr = vga_a[k];
   endtask

endmodule
